// File: rtl/gray_step_sequencer.sv
// rtl/gray_step_sequencer.sv - prescaled N-bit up/down Gray-code LED sequencer with load and step/wrap strobes.
// Optional feature: define GRAY_PINGPONG_EN for bouncing count between 0 and max instead of modulo wrap.
module gray_step_sequencer #(
  parameter int N        = 4,
  parameter int DISTANCE = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] leds,
  output logic [N-1:0] count_bin,
  output logic         tick,
  output logic         wrap
);

  localparam int              PW      = $clog2(DISTANCE + 1);
  localparam logic [PW-1:0]   PRE_MAX = PW'(DISTANCE);
  localparam logic [N-1:0]    CNT_MAX = '1;

  typedef enum logic {ST_UP, ST_DOWN} dir_state_e;

  dir_state_e    state_q, state_d, step_state;
  logic [PW-1:0] pre_q, pre_d;
  logic [N-1:0]  cnt_q, cnt_d, step_cnt;
  logic [N-1:0]  leds_q, leds_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          step_wrap;

  // Candidate result of a step, evaluated every cycle and used only when the prescaler expires.
  always_comb begin
    step_cnt   = cnt_q;
    step_wrap  = 1'b0;
    step_state = state_q;
`ifdef GRAY_PINGPONG_EN
    if (state_q == ST_UP) begin
      if (cnt_q == CNT_MAX) begin
        step_cnt   = cnt_q - N'(1);
        step_state = ST_DOWN;
        step_wrap  = 1'b1;
      end else begin
        step_cnt = cnt_q + N'(1);
      end
    end else begin
      if (cnt_q == '0) begin
        step_cnt   = N'(1);
        step_state = ST_UP;
        step_wrap  = 1'b1;
      end else begin
        step_cnt = cnt_q - N'(1);
      end
    end
`else
    step_state = dir ? ST_DOWN : ST_UP;
    if (dir) begin
      step_cnt  = cnt_q - N'(1);
      step_wrap = (cnt_q == '0);
    end else begin
      step_cnt  = cnt_q + N'(1);
      step_wrap = (cnt_q == CNT_MAX);
    end
`endif
  end

  always_comb begin
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      cnt_d = load_val;
      pre_d = '0;
`ifdef GRAY_PINGPONG_EN
      state_d = dir ? ST_DOWN : ST_UP;
`endif
    end else if (en) begin
      if (pre_q == PRE_MAX) begin
        pre_d   = '0;
        cnt_d   = step_cnt;
        state_d = step_state;
        tick_d  = 1'b1;
        wrap_d  = step_wrap;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
    leds_d = cnt_d ^ (cnt_d >> 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      leds_q  <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      state_q <= ST_UP;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      leds_q  <= leds_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      state_q <= state_d;
    end
  end

  assign leds      = leds_q;
  assign count_bin = cnt_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_gray_step_sequencer.sv
// tb/tb_gray_step_sequencer.sv - randomized and directed checks of gray_step_sequencer against a behavioural model.
module tb_gray_step_sequencer;
  localparam int N    = 4;
  localparam int DIST = 10;
  localparam int MAX  = 15;
`ifdef GRAY_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         dir = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] leds;
  logic [N-1:0] count_bin;
  logic         tick;
  logic         wrap;

  int n_chk  = 0;
  int n_fail = 0;

  int m_cnt = 0;
  int m_pre = 0;
  bit m_up  = 1'b1;
  bit m_tick = 1'b0;
  bit m_wrap = 1'b0;

  gray_step_sequencer #(.N(N), .DISTANCE(DIST)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .leds(leds), .count_bin(count_bin), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int b);
    int g = 0;
    for (int i = 0; i < N; i++) begin
      bit hi = (i + 1 < N) ? b[i+1] : 1'b0;
      g[i] = b[i] ^ hi;
    end
    return g;
  endfunction

  // Behavioural model: a cycle counter, an integer count and a direction flag.
  always @(posedge clk or negedge rst) begin : model
    int nxt;
    bit w;
    bit up;
    if (!rst) begin
      m_cnt <= 0; m_pre <= 0; m_up <= 1'b1; m_tick <= 1'b0; m_wrap <= 1'b0;
    end else if (load) begin
      m_cnt <= int'(load_val); m_pre <= 0; m_tick <= 1'b0; m_wrap <= 1'b0;
      if (PP) m_up <= !dir;
    end else if (en && m_pre == DIST) begin
      up  = PP ? m_up : !dir;
      nxt = up ? m_cnt + 1 : m_cnt - 1;
      w   = 1'b0;
      if (nxt > MAX) begin
        w = 1'b1;
        if (PP) begin nxt = MAX - 1; up = 1'b0; end else nxt = 0;
      end else if (nxt < 0) begin
        w = 1'b1;
        if (PP) begin nxt = 1; up = 1'b1; end else nxt = MAX;
      end
      m_cnt <= nxt; m_up <= up; m_pre <= 0; m_tick <= 1'b1; m_wrap <= w;
    end else begin
      m_tick <= 1'b0; m_wrap <= 1'b0;
      if (en) m_pre <= m_pre + 1;
    end
  end

  always @(negedge clk) begin
    check("cmp_count", count_bin, m_cnt);
    check("cmp_leds", leds, gray_of(m_cnt));
    check("cmp_tick", tick, m_tick);
    check("cmp_wrap", wrap, m_wrap);
  end

  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick && cyc < 200);
    if (!tick) check("tick_timeout", 0, 1);
  endtask

  task automatic do_reset(input logic d);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    dir = d; en = 1'b1; load = 1'b0; rst = 1'b1;
  endtask

  initial begin
    int cyc;
    int hold;
    int exp_leds [4] = '{1, 3, 2, 6};

    #1;
    check("reset_count", count_bin, 0);
    check("reset_leds", leds, 0);
    check("reset_tick", tick, 0);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; dir = 1'b0;

    for (int k = 0; k < 4; k++) begin
      wait_tick(cyc);
      check("t1_period", cyc, 11);
      check("t1_leds", leds, exp_leds[k]);
    end
    for (int k = 4; k < 16; k++) wait_tick(cyc);
`ifndef GRAY_PINGPONG_EN
    check("t2_count_wrap", count_bin, 0);
    check("t2_leds_wrap", leds, 0);
    check("t2_wrap", wrap, 1);
`endif

    do_reset(1'b1);
    wait_tick(cyc);
`ifndef GRAY_PINGPONG_EN
    check("t3_count1", count_bin, 15);
    check("t3_leds1", leds, 4'b1000);
    check("t3_wrap1", wrap, 1);
`endif
    wait_tick(cyc);
`ifndef GRAY_PINGPONG_EN
    check("t3_count2", count_bin, 14);
    check("t3_leds2", leds, 4'b1001);
`endif

    dir = 1'b0;
    wait_tick(cyc);
    repeat (6) @(negedge clk);
    load = 1'b1; load_val = 4'd5;
    @(negedge clk);
    load = 1'b0;
    check("t4_load_count", count_bin, 5);
    check("t4_load_leds", leds, 4'b0111);
    check("t4_load_tick", tick, 0);
    wait_tick(cyc);
    check("t4_period", cyc, 11);
    check("t4_count", count_bin, 6);
    check("t4_leds", leds, 4'b0101);

    repeat (4) @(negedge clk);
    en = 1'b0;
    hold = int'(leds);
    repeat (20) @(negedge clk);
    check("t5_frozen", leds, hold);
    en = 1'b1;
    wait_tick(cyc);
    check("t5_resume", cyc, 7);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_async_count", count_bin, 0);
    check("t5_async_leds", leds, 0);
    check("t5_async_tick", tick, 0);
    @(negedge clk);
    rst = 1'b1;

`ifdef GRAY_PINGPONG_EN
    dir = 1'b0; load = 1'b1; load_val = 4'd14;
    @(negedge clk);
    load = 1'b0; dir = 1'b1;
    wait_tick(cyc); check("t6_c15", count_bin, 15); check("t6_w15", wrap, 0);
    wait_tick(cyc); check("t6_c14", count_bin, 14); check("t6_w14", wrap, 1);
    wait_tick(cyc); check("t6_c13", count_bin, 13); check("t6_w13", wrap, 0);
    dir = 1'b1; load = 1'b1; load_val = 4'd1;
    @(negedge clk);
    load = 1'b0; dir = 1'b0;
    wait_tick(cyc); check("t6_c0", count_bin, 0); check("t6_w0", wrap, 0);
    wait_tick(cyc); check("t6_c1", count_bin, 1); check("t6_w1", wrap, 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en       = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 59) == 0);
      load_val = N'($urandom_range(0, MAX));
      if ($urandom_range(0, 39) == 0) dir = ~dir;
      if ($urandom_range(0, 799) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
